// File: rtl/spi_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_if
// Purpose  : Command/response bundle between the SPI slave and spi_ram.
// Revision : 1.0
// ============================================================================
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err_wr_seq;
    logic       err_rd_seq;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  err_wr_seq,
        input  err_rd_seq
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output err_wr_seq,
        output err_rd_seq
    );
endinterface
`default_nettype wire

// File: rtl/spi_ram.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram
// Purpose  : Command-decoded byte RAM behind the SPI slave, with timed read hold.
// Revision : 1.0
// ============================================================================
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_CYCLES = 10
) (
    input  logic     clk,
    input  logic     rst,
    spi_ram_if.slave bus
);

    if (MEM_DEPTH != 2 ** ADDR_SIZE) begin : g_bad_depth
        $error("spi_ram: MEM_DEPTH must equal 2**ADDR_SIZE");
    end
    if (TX_CYCLES < 9 || TX_CYCLES > 63) begin : g_bad_tx_cycles
        $error("spi_ram: TX_CYCLES must be in 9..63");
    end

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    localparam logic [5:0] TX_LOAD = 6'(TX_CYCLES - 1);

    logic [7:0]           mem_q [MEM_DEPTH];
    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q,    wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q,    rd_addr_d;
    logic                 wa_seen_q,    wa_seen_d;
    logic                 ra_seen_q,    ra_seen_d;
    logic [5:0]           tx_cnt_q,     tx_cnt_d;
    logic                 tx_valid_q,   tx_valid_d;
    logic [7:0]           dout_q,       dout_d;
    logic                 err_wr_q,     err_wr_d;
    logic                 err_rd_q,     err_rd_d;

    logic                 cmd_accept;
    logic                 mem_we;
    cmd_e                 cmd;

    assign cmd = cmd_e'(bus.din[9:8]);

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wa_seen_d  = wa_seen_q;
        ra_seen_d  = ra_seen_q;
        tx_cnt_d   = tx_cnt_q;
        tx_valid_d = tx_valid_q;
        dout_d     = dout_q;
        err_wr_d   = err_wr_q;
        err_rd_d   = err_rd_q;
        mem_we     = 1'b0;
        cmd_accept = bus.rx_valid && !rx_valid_q;

        if (cmd_accept) begin
            // Any accepted command ends a running hold; read-data re-arms it below.
            tx_valid_d = 1'b0;
            tx_cnt_d   = '0;
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = bus.din[ADDR_SIZE-1:0];
                    wa_seen_d = 1'b1;
                end
                CMD_WR_DATA: begin
                    mem_we = 1'b1;
                    if (!wa_seen_q) err_wr_d = 1'b1;
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = bus.din[ADDR_SIZE-1:0];
                    ra_seen_d = 1'b1;
                end
                CMD_RD_DATA: begin
                    dout_d     = mem_q[rd_addr_q];
                    tx_valid_d = 1'b1;
                    tx_cnt_d   = TX_LOAD;
                    ra_seen_d  = 1'b0;
                    if (!ra_seen_q) err_rd_d = 1'b1;
                end
            endcase
        end else if (tx_valid_q) begin
            if (tx_cnt_q == '0) tx_valid_d = 1'b0;
            else                tx_cnt_d   = tx_cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wa_seen_q  <= 1'b0;
            ra_seen_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_valid_q <= 1'b0;
            dout_q     <= '0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wa_seen_q  <= wa_seen_d;
            ra_seen_q  <= ra_seen_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_valid_q <= tx_valid_d;
            dout_q     <= dout_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    // Array kept out of the reset branch so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[wr_addr_q] <= bus.din[7:0];
    end

    assign bus.dout       = dout_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.err_wr_seq = err_wr_q;
    assign bus.err_rd_seq = err_rd_q;

endmodule
`default_nettype wire
